// File: rtl/readout_packetizer.sv
// Buffers DEPTH samples, then emits HEADER, [seq], length, payload, checksum.
// Define READOUT_PKT_SEQ_EN to insert a sequence-number byte after the header.
module readout_packetizer #(
    parameter int                 DATA_W = 8,
    parameter int                 DEPTH  = 8,
    parameter logic [DATA_W-1:0]  HEADER = DATA_W'(8'hA5)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic [7:0]        pkt_count,
    output logic              overflow
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {
        FILL,
        HDR,
`ifdef READOUT_PKT_SEQ_EN
        SEQ,
`endif
        LEN,
        PAY,
        CSUM
    } state_t;

    state_t            state, state_nxt;
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [DATA_W-1:0] csum;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              in_fire, out_fire;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    // rst_n gates the handshakes so nothing is offered while reset is held
    always_comb begin
        in_ready  = rst_n && ena && (state == FILL);
        out_valid = rst_n && ena && (state != FILL);
        out_last  = rst_n && (state == CSUM);
        out_data  = '0;
        state_nxt = state;
        case (state)
            FILL: if (in_fire && wr_ptr == PW'(DEPTH-1)) state_nxt = HDR;
            HDR: begin
                out_data = HEADER;
`ifdef READOUT_PKT_SEQ_EN
                if (out_fire) state_nxt = SEQ;
`else
                if (out_fire) state_nxt = LEN;
`endif
            end
`ifdef READOUT_PKT_SEQ_EN
            SEQ: begin
                out_data = DATA_W'(pkt_count);
                if (out_fire) state_nxt = LEN;
            end
`endif
            LEN: begin
                out_data = DATA_W'(DEPTH);
                if (out_fire) state_nxt = PAY;
            end
            PAY: begin
                out_data = mem[rd_ptr];
                if (out_fire && rd_ptr == PW'(DEPTH-1)) state_nxt = CSUM;
            end
            CSUM: begin
                out_data = csum;
                if (out_fire) state_nxt = FILL;
            end
            default: state_nxt = FILL;
        endcase
    end

    // Payload storage carries no reset so it can map onto RAM
    always_ff @(posedge clk) begin
        if (rst_n && in_fire) mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= FILL;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            csum      <= '0;
            pkt_count <= '0;
            overflow  <= 1'b0;
        end else if (ena) begin
            state <= state_nxt;
            if (in_valid && !in_ready) overflow <= 1'b1;
            if (in_fire) begin
                wr_ptr <= (wr_ptr == PW'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
                csum   <= csum + in_data;
            end
            if (out_fire && state == PAY)
                rd_ptr <= (rd_ptr == PW'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
            if (out_fire && state == CSUM) begin
                csum      <= '0;
                pkt_count <= pkt_count + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_readout_packetizer.sv
// Self-checking bench: directed packet table, handshake corner cases and a
// randomized run checked cycle by cycle against a byte-queue packet model.
module tb_readout_packetizer;
    localparam int DEPTH = 4;
`ifdef READOUT_PKT_SEQ_EN
    localparam int HO = 3;
`else
    localparam int HO = 2;
`endif
    localparam int PLEN = DEPTH + HO + 1;

    logic       clk = 1'b0, rst_n = 1'b0, ena = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0, out_ready = 1'b0;
    logic       in_ready, out_valid, out_last, overflow;
    logic [7:0] out_data, pkt_count;

    readout_packetizer #(.DATA_W(8), .DEPTH(DEPTH), .HEADER(8'hA5)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .pkt_count(pkt_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    // Reference model: whole packets as byte queues
    logic [7:0] q[$];
    logic [7:0] smp[$];
    logic [7:0] got[$];
    int  cnt_m = 0, done_pkts = 0;
    bit  ovf_m = 0, known = 0, accepted = 0;

    typedef struct packed {
        logic [3:0][7:0] s;
        logic [7:0]      cs;
    } vec_t;
    vec_t vt[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic build_pkt();
        logic [7:0] sum = '0;
        q.push_back(8'hA5);
`ifdef READOUT_PKT_SEQ_EN
        q.push_back(8'(cnt_m));
`endif
        q.push_back(8'(DEPTH));
        foreach (smp[i]) begin
            q.push_back(smp[i]);
            sum += smp[i];
        end
        q.push_back(sum);
        smp.delete();
    endtask

    // One clock: check outputs against the model, advance the model, cross the edge
    task automatic step();
        bit eir, eov;
        #1;
        eir = rst_n && ena && (q.size() == 0);
        eov = rst_n && ena && (q.size() != 0);
        chk("in_ready", in_ready, eir);
        chk("out_valid", out_valid, eov);
        if (eov) begin
            chk("out_data", out_data, q[0]);
            chk("out_last", out_last, q.size() == 1);
        end
        if (known) begin
            chk("pkt_count", pkt_count, cnt_m);
            chk("overflow", overflow, ovf_m);
        end
        accepted = 0;
        if (!rst_n) begin
            q.delete(); smp.delete();
            cnt_m = 0; ovf_m = 0; known = 1;
        end else begin
            if (ena && in_valid && !eir) ovf_m = 1;
            if (eir && in_valid) begin
                accepted = 1;
                smp.push_back(in_data);
                if (smp.size() == DEPTH) build_pkt();
            end
            if (eov && out_ready) begin
                got.push_back(out_data);
                void'(q.pop_front());
                if (q.size() == 0) begin
                    cnt_m = (cnt_m + 1) % 256;
                    done_pkts++;
                end
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic feed(input logic [3:0][7:0] s);
        for (int i = 0; i < DEPTH; i++) begin
            int n = 0;
            in_valid = 1; in_data = s[i];
            do begin step(); n++; end while (!accepted && n < 50);
            if (!accepted) chk("feed_timeout", 0, 1);
        end
        in_valid = 0;
    endtask

    task automatic drain(input int nbytes);
        int n = 0;
        out_ready = 1;
        while (got.size() < nbytes && n < 100) begin step(); n++; end
        if (got.size() < nbytes) chk("drain_timeout", got.size(), nbytes);
    endtask

    task automatic cmp_pkt(input string name, input logic [3:0][7:0] s, input logic [7:0] cs);
        chk({name, "_len"}, got.size(), PLEN);
        if (got.size() >= PLEN) begin
            chk({name, "_hdr"}, got[0], 8'hA5);
            chk({name, "_len_byte"}, got[HO-1], DEPTH);
            for (int k = 0; k < DEPTH; k++) chk({name, "_pay"}, got[HO+k], s[k]);
            chk({name, "_csum"}, got[HO+DEPTH], cs);
        end
    endtask

    task automatic do_reset();
        rst_n = 0; step(); step(); rst_n = 1;
        got.delete();
    endtask

    initial begin
        vt[0] = '{s: {8'h04, 8'h03, 8'h02, 8'h01}, cs: 8'h0A};
        vt[1] = '{s: {8'hFF, 8'hFF, 8'hFF, 8'hFF}, cs: 8'hFC};
        vt[2] = '{s: {8'h40, 8'h30, 8'h20, 8'h10}, cs: 8'hA0};
        vt[3] = '{s: {8'h80, 8'h80, 8'h80, 8'h80}, cs: 8'h00};

        ena = 1;
        do_reset();
        chk("reset_pkt_count", pkt_count, 0);
        chk("reset_overflow", overflow, 0);

        // Directed packets with out_ready held high
        for (int i = 0; i < 4; i++) begin
            got.delete();
            out_ready = 1;
            feed(vt[i].s);
            drain(PLEN);
            cmp_pkt("table", vt[i].s, vt[i].cs);
`ifdef READOUT_PKT_SEQ_EN
            if (got.size() > 1) chk("table_seq", got[1], i);
`endif
            if (i == 0) chk("basic_pkt_count", pkt_count, 1);
        end

        // Backpressure on payload byte 02
        begin
            int n = 0;
            got.delete();
            out_ready = 1;
            feed(vt[0].s);
            while (q.size() != 4 && n < 50) begin step(); n++; end
            out_ready = 0;
            for (int k = 0; k < 3; k++) begin
                #1;
                chk("bp_hold_data", out_data, 8'h02);
                chk("bp_hold_valid", out_valid, 1);
                step();
            end
            drain(PLEN);
            cmp_pkt("backpressure", vt[0].s, 8'h0A);
        end

        // Overflow: sample offered during HDR
        got.delete();
        out_ready = 0;
        feed(vt[2].s);
        in_valid = 1; in_data = 8'h77;
        for (int k = 0; k < 3; k++) step();
        in_valid = 0;
        chk("ovf_set", overflow, 1);
        step();
        chk("ovf_sticky", overflow, 1);
        drain(PLEN);
        cmp_pkt("overflow_pkt", vt[2].s, 8'hA0);

        // Reset during PAY, then a fresh packet
        begin
            int n = 0;
            got.delete();
            out_ready = 1;
            feed(vt[1].s);
            while (q.size() > 3 && n < 50) begin step(); n++; end
            do_reset();
            feed({8'h08, 8'h07, 8'h06, 8'h05});
            drain(PLEN);
            cmp_pkt("reset_mid", {8'h08, 8'h07, 8'h06, 8'h05}, 8'h1A);
            chk("reset_mid_count", pkt_count, 1);
        end

        // ena gating mid-FILL and in PAY
        begin
            int n = 0;
            got.delete();
            out_ready = 1;
            in_valid = 1; in_data = 8'h21; step();
            in_data = 8'h22; step();
            ena = 0; in_data = 8'h99;
            for (int k = 0; k < 5; k++) step();
            chk("ena_no_ovf", overflow, 0);
            ena = 1;
            in_data = 8'h23; step();
            in_data = 8'h24; step();
            in_valid = 0;
            while (q.size() > 4 && n < 50) begin step(); n++; end
            ena = 0;
            for (int k = 0; k < 4; k++) step();
            chk("ena_frozen_got", got.size(), HO + 1);
            ena = 1;
            drain(PLEN);
            cmp_pkt("ena_gate", {8'h24, 8'h23, 8'h22, 8'h21}, 8'h8A);
        end

        // Randomized: 256 packets, pkt_count wraps and seq bytes follow it
        begin
            int n = 0;
            do_reset();
            done_pkts = 0;
            while (done_pkts < 256 && n < 40000) begin
                ena       = ($urandom_range(0, 9) != 0);
                in_valid  = $urandom_range(0, 1) == 1;
                in_data   = 8'($urandom);
                out_ready = ($urandom_range(0, 3) != 0);
                step();
                n++;
            end
            if (done_pkts < 256) chk("random_timeout", done_pkts, 256);
            in_valid = 0; ena = 1; out_ready = 0;
            step();
            chk("wrap_pkt_count", pkt_count, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/readout_packetizer.md
Name: readout_packetizer

Overview:
- Parametrised successor to the fast-readout datapath.
- Collects DEPTH samples from the input port into a local buffer, then emits one framed packet: header, [sequence], length, payload, checksum.
- Sits between the input capture stage and the output pin router.
- Valid/ready on both sides, with a sticky overflow flag and a packet counter.

Parameters:
- DATA_W, 8, width of samples and of every output packet byte.
- DEPTH, 8, samples per packet; power of two, 2..64.
- HEADER, 8'hA5, first byte of every packet (DATA_W bits).

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- rst_n, input, 1, synchronous active-low reset.
- ena, input, 1, global enable; low freezes all state.
- in_data, input, DATA_W, sample.
- in_valid, input, 1, sample present.
- in_ready, output, 1, block accepts a sample this cycle.
- out_data, output, DATA_W, packet byte.
- out_valid, output, 1, out_data is valid.
- out_ready, input, 1, downstream accepts the byte.
- out_last, output, 1, high on the checksum byte only.
- pkt_count, output, 8, completed packets; wraps 255->0.
- overflow, output, 1, sticky: a sample was offered while the block was not ready.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - state=FILL, wr_ptr=0, rd_ptr=0, csum=0, pkt_count=0, overflow=0.
  - in_ready=0, out_valid=0, out_last=0, out_data=0.
  - Reset mid-packet discards buffer contents and any partial packet. The first packet after reset starts with HEADER.
- Input transfer: in_valid & in_ready at an edge.
- Output transfer: out_valid & out_ready at an edge.
- FSM states: FILL, HDR, SEQ (feature only), LEN, PAY, CSUM.
- FILL:
  - in_ready=ena; out_valid=0.
  - Each input transfer writes buf[wr_ptr], adds the sample to csum (mod 2^DATA_W), and increments wr_ptr.
  - The transfer that writes index DEPTH-1 moves the FSM to HDR next cycle and wraps wr_ptr to 0.
- HDR: out_data=HEADER, out_valid=ena. On transfer -> SEQ if the feature is enabled, else -> LEN.
- LEN: out_data=DEPTH (zero-extended to DATA_W). On transfer -> PAY.
- PAY:
  - out_data=buf[rd_ptr]; each transfer increments rd_ptr.
  - The transfer of index DEPTH-1 wraps rd_ptr to 0 and moves to CSUM.
- CSUM:
  - out_data=csum (payload-only sum mod 2^DATA_W), out_last=1.
  - On transfer: csum cleared, pkt_count+1 (wrapping), -> FILL.
- Input/output exclusivity: in_ready=0 in every state except FILL. Output is combinational from state/pointers/buffer; there is no extra register stage.
- Throughput: a packet can stream at one byte per cycle with out_ready held high. The first input of the next packet is accepted the cycle after the CSUM transfer.
- Output hold: out_data and out_valid stay stable while out_valid=1 and out_ready=0.
- overflow: set when ena & in_valid & !in_ready; cleared only by reset.
- ena=0:
  - in_ready=0, out_valid=0; no pointer, state, csum or counter changes.
  - overflow is not set.
  - Resuming ena=1 continues exactly where the block stopped.
- Simultaneous in_valid and out_ready: only the transfer legal in the current state occurs.

Optional Feature:
- Macro: READOUT_PKT_SEQ_EN.
- Defined:
  - SEQ state inserted after HDR; out_data = pkt_count (low DATA_W bits, zero-extended), i.e. the sequence number of the current packet.
  - Packet length becomes DEPTH+4 bytes.
  - csum still covers the payload only.
- Undefined: no SEQ state; packet is DEPTH+3 bytes.

Test Plan:
- Basic packet (DEPTH=4, out_ready=1):
  - Stimulus: input 01,02,03,04.
  - Required output: A5,04,01,02,03,04,0A; out_last only on 0A; pkt_count=1.
- Checksum wrap:
  - Stimulus: input FF,FF,FF,FF.
  - Required: checksum byte FC.
- Backpressure:
  - Stimulus: drop out_ready for 3 cycles during PAY, at byte 02.
  - Required: 02 held stable with out_valid=1; stream resumes without loss or duplication.
- Overflow:
  - Stimulus: hold in_valid=1 during HDR.
  - Required: in_ready=0, overflow=1 and sticky; the packet is unchanged.
- Reset mid-packet:
  - Stimulus: assert rst_n=0 during PAY, then send 05,06,07,08.
  - Required: fresh packet A5,04,05,06,07,08,1A; pkt_count=1.
- ena gating and sequence number:
  - Stimulus: drop ena mid-FILL and in PAY, then send 256 packets with READOUT_PKT_SEQ_EN defined.
  - Required: no state progress while ena=0; SEQ bytes run 00..FF then 00; pkt_count wraps to 0.
